// File: rtl/des_cmd_pkg.sv
// Shared definitions for the DES command controller: command and status
// codes, the controller state encoding and the payload length.
package des_cmd_pkg;

    localparam logic [7:0] CMD_SET_KEY  = 8'h00;
    localparam logic [7:0] CMD_ENC      = 8'h02;
    localparam logic [7:0] CMD_DEC      = 8'h03;

    localparam logic [7:0] STAT_OK      = 8'h80;  // OR-ed onto the command code
    localparam logic [7:0] STAT_NO_KEY  = 8'hFE;
    localparam logic [7:0] STAT_BAD_CMD = 8'hFF;

    localparam int unsigned PL_LEN = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_PL   = 3'd1,
        APPLY   = 3'd2,
        RUN     = 3'd3,
        TX_STAT = 3'd4,
        TX_DATA = 3'd5
    } state_t;

    function automatic logic is_known_cmd(input logic [7:0] code);
        return (code == CMD_SET_KEY) || (code == CMD_ENC) || (code == CMD_DEC);
    endfunction

endpackage

// File: rtl/des_cmd_ctrl_shreg.sv
// des_byte_shreg: 64-bit byte shift register.
//   clk, rst    : clock, asynchronous active-high reset
//   shift_en    : shift left one byte, shift_byte enters at [7:0]
//   shift_byte  : byte shifted in (zero when draining for transmit)
//   load_en     : parallel load of load_data (has priority over shift)
//   load_data   : 64-bit parallel load value
//   q           : register contents; q[63:56] is the next byte out
module des_byte_shreg (
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic [7:0]  shift_byte,
    input  logic        load_en,
    input  logic [63:0] load_data,
    output logic [63:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[55:0], shift_byte};
        end
    end

endmodule

// File: rtl/des_cmd_ctrl.sv
// des_cmd_ctrl: responder end of the host UART command protocol.
// Parses {cmd, 8 payload bytes} frames, loads key/text into the DES core,
// starts it and returns a status byte (+8 result bytes for ENC/DEC).
//   Clk, Rst                 : clock, asynchronous active-high reset
//   i_fRxDone, i_RxData      : received byte strobe and data
//   i_fTxReady, i_fTxDone    : UART_TX idle / byte-sent strobe
//   o_fTx, o_TxData          : transmit request and byte
//   o_Key, o_Text, o_fDec    : DES core key, input block, direction
//   o_fStart                 : DES start strobe
//   i_fDesDone, i_DesResult  : DES completion strobe and result
//   o_LED                    : {fKeyValid, fBusy, fErr, 2'b0, state}
module des_cmd_ctrl
    import des_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        i_fRxDone,
    input  logic [7:0]  i_RxData,
    input  logic        i_fTxReady,
    input  logic        i_fTxDone,
    output logic        o_fTx,
    output logic [7:0]  o_TxData,
    output logic [63:0] o_Key,
    output logic [63:0] o_Text,
    output logic        o_fDec,
    output logic        o_fStart,
    input  logic        i_fDesDone,
    input  logic [63:0] i_DesResult,
    output logic [7:0]  o_LED
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    CNT_LAST = 3'(PL_LEN - 1);

    state_t        state_q, state_n;
    logic [2:0]    cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic [7:0]    cmd_q, status_q;
    logic [63:0]   key_q, text_q, sr_q;
    logic          dec_q, key_valid_q, err_q, tx_sent_q, send_data_q;

    logic          sr_shift, sr_load, cnt_inc, drop, timeout, run_done;
    logic          apply_key, apply_text, apply_nokey;
    logic [7:0]    sr_byte;

    des_byte_shreg u_shreg (
        .clk        (Clk),
        .rst        (Rst),
        .shift_en   (sr_shift),
        .shift_byte (sr_byte),
        .load_en    (sr_load),
        .load_data  (i_DesResult),
        .q          (sr_q)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        o_fTx       = 1'b0;
        o_fStart    = 1'b0;
        sr_shift    = 1'b0;
        sr_byte     = '0;
        sr_load     = 1'b0;
        cnt_inc     = 1'b0;
        timeout     = 1'b0;
        run_done    = 1'b0;
        apply_key   = 1'b0;
        apply_text  = 1'b0;
        apply_nokey = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_fRxDone) begin
                    state_n = is_known_cmd(i_RxData) ? RX_PL : TX_STAT;
                end
            end
            RX_PL: begin
                // A byte in the expiry cycle wins over the timeout.
                if (i_fRxDone) begin
                    sr_shift = 1'b1;
                    sr_byte  = i_RxData;
                    cnt_inc  = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_n = APPLY;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
            end
            APPLY: begin
                if (cmd_q == CMD_SET_KEY) begin
                    apply_key = 1'b1;
                    state_n   = TX_STAT;
                end else if (key_valid_q) begin
                    apply_text = 1'b1;
                    o_fStart   = 1'b1;
                    state_n    = RUN;
                end else begin
                    apply_nokey = 1'b1;
                    state_n     = TX_STAT;
                end
            end
            RUN: begin
                if (i_fDesDone) begin
                    run_done = 1'b1;
                    sr_load  = 1'b1;
                    state_n  = TX_STAT;
                end
            end
            TX_STAT: begin
                if (!tx_sent_q) begin
                    o_fTx = i_fTxReady;
                end else if (i_fTxDone) begin
                    state_n = send_data_q ? TX_DATA : IDLE;
                end
            end
            TX_DATA: begin
                if (!tx_sent_q) begin
                    o_fTx = i_fTxReady;
                end else if (i_fTxDone) begin
                    sr_shift = 1'b1;
                    cnt_inc  = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        drop = i_fRxDone && (state_q inside {APPLY, RUN, TX_STAT, TX_DATA});
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            cmd_q       <= '0;
            status_q    <= '0;
            key_q       <= '0;
            text_q      <= '0;
            dec_q       <= 1'b0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            tx_sent_q   <= 1'b0;
            send_data_q <= 1'b0;
        end else begin
            cnt_q    <= (state_n != state_q) ? '0 : cnt_q + 3'(cnt_inc);
            to_cnt_q <= (state_q == RX_PL && state_n == RX_PL && !i_fRxDone)
                        ? to_cnt_q + TW'(1) : '0;

            if (o_fTx) begin
                tx_sent_q <= 1'b1;
            end else if (i_fTxDone) begin
                tx_sent_q <= 1'b0;
            end

            if (state_q == IDLE && i_fRxDone) begin
                cmd_q <= i_RxData;
                if (!is_known_cmd(i_RxData)) begin
                    status_q    <= STAT_BAD_CMD;
                    send_data_q <= 1'b0;
                end
            end
            if (apply_key) begin
                key_q       <= sr_q;
                key_valid_q <= 1'b1;
                status_q    <= cmd_q | STAT_OK;
                send_data_q <= 1'b0;
            end
            if (apply_text) begin
                text_q <= sr_q;
                dec_q  <= (cmd_q == CMD_DEC);
            end
            if (apply_nokey) begin
                status_q    <= STAT_NO_KEY;
                send_data_q <= 1'b0;
            end
            if (run_done) begin
                status_q    <= cmd_q | STAT_OK;
                send_data_q <= 1'b1;
            end

            if (drop || timeout) begin
                err_q <= 1'b1;
            end else if (apply_key || run_done) begin
                err_q <= 1'b0;
            end
        end
    end

    // The new key/text is forwarded during the APPLY cycle itself so the core
    // sees it together with o_fStart; the registers hold it from then on.
    assign o_Key    = apply_key  ? sr_q : key_q;
    assign o_Text   = apply_text ? sr_q : text_q;
    assign o_fDec   = apply_text ? (cmd_q == CMD_DEC) : dec_q;
    assign o_TxData = (state_q == TX_STAT) ? status_q :
                      (state_q == TX_DATA) ? sr_q[63:56] : '0;
    assign o_LED    = {key_valid_q, state_q != IDLE, err_q, 2'b00, state_q};

endmodule
